rom_bus_arbiter: RTL and testbench

//  Shares one synchronous single-port 32-bit ROM between the CPU instruction bus (ibus) and data bus (dbus).

---
 rtl/rom_arb_pkg.sv | 17 +
 rtl/rom_arb_pick.sv | 36 +++
 rtl/rom_bus_arbiter.sv | 107 ++++++++++
 tb/tb_rom_bus_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the ROM bus arbiter.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IBUS = 1'b0,
        GNT_DBUS = 1'b1
    } grant_t;

    localparam int ROM_LATENCY = 1;

endpackage

// File: rtl/rom_arb_pick.sv
// Combinational winner select between ibus and dbus requests.
// ROM_ARB_RR_EN selects round-robin; otherwise ibus has fixed priority.
module rom_arb_pick
    import rom_arb_pkg::*;
(
    input  logic   ibus_cyc,
    input  logic   dbus_cyc,
    input  grant_t rr_ptr,
    output logic   vld,
    output grant_t gnt
);

    assign vld = ibus_cyc | dbus_cyc;

`ifdef ROM_ARB_RR_EN
    always_comb begin
        gnt = GNT_IBUS;
        if (ibus_cyc && dbus_cyc) begin
            gnt = rr_ptr;
        end else if (dbus_cyc) begin
            gnt = GNT_DBUS;
        end
    end
`else
    logic unused_rr_ptr;
    assign unused_rr_ptr = rr_ptr;

    always_comb begin
        gnt = GNT_IBUS;
        if (!ibus_cyc && dbus_cyc) begin
            gnt = GNT_DBUS;
        end
    end
`endif

endmodule

// File: rtl/rom_bus_arbiter.sv
// Shares one single-port registered ROM between the ibus and dbus read requesters.
// Define ROM_ARB_RR_EN for round-robin arbitration; default is fixed ibus priority.
module rom_bus_arbiter
    import rom_arb_pkg::*;
#(
    parameter  int ROM_SIZE      = 1024,
    localparam int ROM_ADDR_BITS = $clog2(ROM_SIZE / 4)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [31:0]              i_ibus_adr,
    input  logic                     i_ibus_cyc,
    output logic [31:0]              o_ibus_rdt,
    output logic                     o_ibus_ack,
    input  logic [31:0]              i_dbus_adr,
    input  logic                     i_dbus_cyc,
    input  logic                     i_dbus_we,
    output logic [31:0]              o_dbus_rdt,
    output logic                     o_dbus_ack,
    output logic [ROM_ADDR_BITS-1:0] o_rom_addr,
    output logic                     o_rom_ce,
    input  logic [31:0]              i_rom_data
);

    if (ROM_LATENCY != 1 || ROM_SIZE < 8) begin : g_bad_cfg
        $error("rom_bus_arbiter: unsupported configuration");
    end

    state_t state;
    grant_t grant;
    grant_t rr_ptr;
    logic   wr_skip;

    logic   pick_vld;
    grant_t pick_gnt;

    logic [ROM_ADDR_BITS-1:0] ibus_word;
    logic [ROM_ADDR_BITS-1:0] dbus_word;

    // Byte offset and bits above the ROM size are dropped, so addresses alias.
    assign ibus_word = i_ibus_adr[ROM_ADDR_BITS+1:2];
    assign dbus_word = i_dbus_adr[ROM_ADDR_BITS+1:2];

    logic unused_adr_bits;
    assign unused_adr_bits = ^{i_ibus_adr[31:ROM_ADDR_BITS+2], i_ibus_adr[1:0],
                               i_dbus_adr[31:ROM_ADDR_BITS+2], i_dbus_adr[1:0]};

    rom_arb_pick u_pick (
        .ibus_cyc (i_ibus_cyc),
        .dbus_cyc (i_dbus_cyc),
        .rr_ptr   (rr_ptr),
        .vld      (pick_vld),
        .gnt      (pick_gnt)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            grant      <= GNT_IBUS;
            rr_ptr     <= GNT_IBUS;
            wr_skip    <= 1'b0;
            o_rom_ce   <= 1'b0;
            o_rom_addr <= '0;
            o_ibus_ack <= 1'b0;
            o_dbus_ack <= 1'b0;
        end else begin
            o_ibus_ack <= 1'b0;
            o_dbus_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant      <= pick_gnt;
                        rr_ptr     <= (pick_gnt == GNT_IBUS) ? GNT_DBUS : GNT_IBUS;
                        o_rom_addr <= (pick_gnt == GNT_IBUS) ? ibus_word : dbus_word;
                        if (pick_gnt == GNT_DBUS && i_dbus_we) begin
                            // Writes to ROM are acknowledged without touching it.
                            wr_skip    <= 1'b1;
                            o_dbus_ack <= 1'b1;
                            state      <= DATA;
                        end else begin
                            wr_skip  <= 1'b0;
                            o_rom_ce <= 1'b1;
                            state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    o_rom_ce   <= 1'b0;
                    o_ibus_ack <= (grant == GNT_IBUS);
                    o_dbus_ack <= (grant == GNT_DBUS);
                    state      <= DATA;
                end
                DATA: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ROM output is already registered; it is only steered and gated here.
    assign o_ibus_rdt = o_ibus_ack ? i_rom_data : 32'h0;
    assign o_dbus_rdt = (o_dbus_ack && !wr_skip) ? i_rom_data : 32'h0;

endmodule

// File: tb/tb_rom_bus_arbiter.sv
// Directed bench for rom_bus_arbiter with a small registered ROM model.
module tb_rom_bus_arbiter;

    localparam int AW = 8;

    logic          clk;
    logic          resetn;
    logic [31:0]   ibus_adr;
    logic          ibus_cyc;
    logic [31:0]   ibus_rdt;
    logic          ibus_ack;
    logic [31:0]   dbus_adr;
    logic          dbus_cyc;
    logic          dbus_we;
    logic [31:0]   dbus_rdt;
    logic          dbus_ack;
    logic [AW-1:0] rom_addr;
    logic          rom_ce;
    logic [31:0]   rom_data;

    logic [31:0] mem [0:255];

    int checks;
    int errors;

    rom_bus_arbiter #(.ROM_SIZE(1024)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .i_ibus_adr (ibus_adr),
        .i_ibus_cyc (ibus_cyc),
        .o_ibus_rdt (ibus_rdt),
        .o_ibus_ack (ibus_ack),
        .i_dbus_adr (dbus_adr),
        .i_dbus_cyc (dbus_cyc),
        .i_dbus_we  (dbus_we),
        .o_dbus_rdt (dbus_rdt),
        .o_dbus_ack (dbus_ack),
        .o_rom_addr (rom_addr),
        .o_rom_ce   (rom_ce),
        .i_rom_data (rom_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_ce) rom_data <= mem[rom_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ibus_cyc = 1'b0;
        dbus_cyc = 1'b0;
        dbus_we  = 1'b0;
        ibus_adr = 32'h0;
        dbus_adr = 32'h0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle_inputs();
        tick();
        tick();
        checks++; if (rom_ce !== 1'b0) begin errors++; $display("FAIL reset_ce got %b want 0", rom_ce); end
        checks++; if (rom_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", rom_addr); end
        checks++; if (ibus_ack !== 1'b0 || dbus_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b%b want 00", ibus_ack, dbus_ack); end
        checks++; if (ibus_rdt !== 32'h0 || dbus_rdt !== 32'h0) begin errors++; $display("FAIL reset_rdt got %h %h want 0 0", ibus_rdt, dbus_rdt); end
        resetn = 1'b1;
    endtask

    task automatic test_ibus_only();
        apply_reset();
        ibus_adr = 32'h0000_0010;
        ibus_cyc = 1'b1;
        tick();
        checks++; if (rom_ce !== 1'b1) begin errors++; $display("FAIL ionly_ce got %b want 1", rom_ce); end
        checks++; if (rom_addr !== 8'd4) begin errors++; $display("FAIL ionly_addr got %0d want 4", rom_addr); end
        checks++; if (ibus_ack !== 1'b0) begin errors++; $display("FAIL ionly_early_ack got %b want 0", ibus_ack); end
        tick();
        checks++; if (ibus_ack !== 1'b1) begin errors++; $display("FAIL ionly_ack got %b want 1", ibus_ack); end
        checks++; if (ibus_rdt !== 32'hDEADBEEF) begin errors++; $display("FAIL ionly_rdt got %h want deadbeef", ibus_rdt); end
        checks++; if (dbus_ack !== 1'b0) begin errors++; $display("FAIL ionly_dack got %b want 0", dbus_ack); end
        checks++; if (rom_ce !== 1'b0) begin errors++; $display("FAIL ionly_ce_off got %b want 0", rom_ce); end
        ibus_cyc = 1'b0;
        tick();
        checks++; if (ibus_ack !== 1'b0 || ibus_rdt !== 32'h0) begin errors++; $display("FAIL ionly_pulse got %b %h want 0 0", ibus_ack, ibus_rdt); end
        tick();
        checks++; if (rom_ce !== 1'b0) begin errors++; $display("FAIL ionly_no_reissue got %b want 0", rom_ce); end
    endtask

    task automatic test_contention();
        apply_reset();
        ibus_adr = 32'h0;
        dbus_adr = 32'h8;
        ibus_cyc = 1'b1;
        dbus_cyc = 1'b1;
        tick();
        checks++; if (rom_ce !== 1'b1 || rom_addr !== 8'd0) begin errors++; $display("FAIL cont_first got ce=%b addr=%0d want ce=1 addr=0", rom_ce, rom_addr); end
        tick();
        checks++; if (ibus_ack !== 1'b1 || ibus_rdt !== 32'hA5A5_0000) begin errors++; $display("FAIL cont_iack got %b %h want 1 a5a50000", ibus_ack, ibus_rdt); end
        checks++; if (dbus_ack !== 1'b0) begin errors++; $display("FAIL cont_dwait got %b want 0", dbus_ack); end
        ibus_cyc = 1'b0;
        tick();
        tick();
        checks++; if (rom_ce !== 1'b1 || rom_addr !== 8'd2) begin errors++; $display("FAIL cont_second got ce=%b addr=%0d want ce=1 addr=2", rom_ce, rom_addr); end
        tick();
        checks++; if (dbus_ack !== 1'b1 || dbus_rdt !== 32'h2222_2222) begin errors++; $display("FAIL cont_dack got %b %h want 1 22222222", dbus_ack, dbus_rdt); end
        checks++; if (ibus_ack !== 1'b0 || ibus_rdt !== 32'h0) begin errors++; $display("FAIL cont_iquiet got %b %h want 0 0", ibus_ack, ibus_rdt); end
        dbus_cyc = 1'b0;
        tick();
        // Pointer now prefers ibus in both arbitration modes.
        ibus_cyc = 1'b1;
        dbus_cyc = 1'b1;
        tick();
        checks++; if (rom_ce !== 1'b1 || rom_addr !== 8'd0) begin errors++; $display("FAIL cont_ptr got ce=%b addr=%0d want ce=1 addr=0", rom_ce, rom_addr); end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        logic exp_i;
        logic exp_d;
        apply_reset();
        ibus_adr = 32'h10;
        dbus_adr = 32'h8;
        ibus_cyc = 1'b1;
        dbus_cyc = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
`ifdef ROM_ARB_RR_EN
            exp_i = (k == 2 || k == 8);
            exp_d = (k == 5 || k == 11);
`else
            exp_i = (k % 3 == 2);
            exp_d = 1'b0;
`endif
            checks++; if (ibus_ack !== exp_i) begin errors++; $display("FAIL b2b_iack cyc%0d got %b want %b", k, ibus_ack, exp_i); end
            checks++; if (dbus_ack !== exp_d) begin errors++; $display("FAIL b2b_dack cyc%0d got %b want %b", k, dbus_ack, exp_d); end
            if (exp_i) begin
                checks++; if (ibus_rdt !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_irdt cyc%0d got %h want deadbeef", k, ibus_rdt); end
            end
            if (exp_d) begin
                checks++; if (dbus_rdt !== 32'h2222_2222) begin errors++; $display("FAIL b2b_drdt cyc%0d got %h want 22222222", k, dbus_rdt); end
            end
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_dbus_write();
        int ce_seen;
        apply_reset();
        ce_seen = 0;
        dbus_adr = 32'h4;
        dbus_we  = 1'b1;
        dbus_cyc = 1'b1;
        tick();
        if (rom_ce) ce_seen++;
        checks++; if (dbus_ack !== 1'b1) begin errors++; $display("FAIL wr_ack got %b want 1", dbus_ack); end
        checks++; if (dbus_rdt !== 32'h0) begin errors++; $display("FAIL wr_rdt got %h want 0", dbus_rdt); end
        dbus_cyc = 1'b0;
        dbus_we  = 1'b0;
        tick();
        if (rom_ce) ce_seen++;
        checks++; if (dbus_ack !== 1'b0) begin errors++; $display("FAIL wr_pulse got %b want 0", dbus_ack); end
        tick();
        if (rom_ce) ce_seen++;
        checks++; if (ce_seen !== 0) begin errors++; $display("FAIL wr_no_ce got %0d want 0", ce_seen); end
        checks++; if (mem[1] !== 32'h1000_0001) begin errors++; $display("FAIL wr_rom_intact got %h want 10000001", mem[1]); end
    endtask

    task automatic test_alias();
        apply_reset();
        dbus_adr = 32'h0000_0403;
        dbus_cyc = 1'b1;
        tick();
        checks++; if (rom_ce !== 1'b1 || rom_addr !== 8'd0) begin errors++; $display("FAIL alias_addr got ce=%b addr=%0d want ce=1 addr=0", rom_ce, rom_addr); end
        tick();
        checks++; if (dbus_ack !== 1'b1 || dbus_rdt !== 32'hA5A5_0000) begin errors++; $display("FAIL alias_data got %b %h want 1 a5a50000", dbus_ack, dbus_rdt); end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_abandon();
        apply_reset();
        ibus_adr = 32'h8;
        ibus_cyc = 1'b1;
        tick();
        ibus_cyc = 1'b0;
        tick();
        checks++; if (ibus_ack !== 1'b1 || ibus_rdt !== 32'h2222_2222) begin errors++; $display("FAIL abandon_ack got %b %h want 1 22222222", ibus_ack, ibus_rdt); end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        int acks;
        apply_reset();
        acks = 0;
        ibus_adr = 32'h10;
        ibus_cyc = 1'b1;
        tick();
        checks++; if (rom_ce !== 1'b1) begin errors++; $display("FAIL rmid_issue got %b want 1", rom_ce); end
        resetn = 1'b0;
        tick();
        if (ibus_ack) acks++;
        checks++; if (rom_ce !== 1'b0 || rom_addr !== 8'd0) begin errors++; $display("FAIL rmid_out got ce=%b addr=%0d want 0 0", rom_ce, rom_addr); end
        checks++; if (ibus_rdt !== 32'h0 || dbus_ack !== 1'b0) begin errors++; $display("FAIL rmid_rdt got %h %b want 0 0", ibus_rdt, dbus_ack); end
        resetn = 1'b1;
        ibus_cyc = 1'b0;
        tick();
        if (ibus_ack) acks++;
        tick();
        if (ibus_ack) acks++;
        checks++; if (acks !== 0) begin errors++; $display("FAIL rmid_no_ack got %0d want 0", acks); end
        ibus_cyc = 1'b1;
        tick();
        checks++; if (rom_ce !== 1'b1 || rom_addr !== 8'd4) begin errors++; $display("FAIL rmid_fresh_ce got ce=%b addr=%0d want 1 4", rom_ce, rom_addr); end
        tick();
        checks++; if (ibus_ack !== 1'b1 || ibus_rdt !== 32'hDEADBEEF) begin errors++; $display("FAIL rmid_fresh_ack got %b %h want 1 deadbeef", ibus_ack, ibus_rdt); end
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rom_data = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'hA5A5_0000;
        mem[2] = 32'h2222_2222;
        mem[4] = 32'hDEADBEEF;
        resetn = 1'b0;
        idle_inputs();

        test_reset();
        test_ibus_only();
        test_contention();
        test_back_to_back();
        test_dbus_write();
        test_alias();
        test_abandon();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
